mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-ported memory.
// Optional round-robin arbitration: define MEM_ARBITER_ROUND_ROBIN_EN; default is fixed data-port priority.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] memory_address,
    output logic [DATA_W-1:0] memory_data_out,
    input  logic [DATA_W-1:0] memory_data_in,
    output logic              memory_write_enable,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              grant_i;
    logic              grant_d;
    logic              owner_d;
    logic              we_r;
    logic [DATA_W-1:0] i_rdata_r;
    logic [DATA_W-1:0] d_rdata_r;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic              last_i;
`endif

    always_comb begin
        state_nx = state;
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        if (!reset && state != ACCESS) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            if (i_req && d_req) begin
                grant_d = last_i;
                grant_i = !last_i;
            end else begin
                grant_i = i_req;
                grant_d = d_req;
            end
`else
            grant_d = d_req;
            grant_i = i_req && !d_req;
`endif
        end
        case (state)
            IDLE:    if (grant_i || grant_d) state_nx = ACCESS;
            ACCESS:  state_nx = RESP;
            RESP:    state_nx = (grant_i || grant_d) ? ACCESS : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            memory_address  <= '0;
            memory_data_out <= '0;
            owner_d         <= 1'b0;
            we_r            <= 1'b0;
            i_rdata_r       <= '0;
            d_rdata_r       <= '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_i          <= 1'b1;
`endif
        end else begin
            state <= state_nx;
            // Write data register only follows data-port grants; fetches leave it holding.
            if (grant_i) begin
                memory_address <= i_addr;
                owner_d        <= 1'b0;
                we_r           <= 1'b0;
            end else if (grant_d) begin
                memory_address  <= d_addr;
                memory_data_out <= d_wdata;
                owner_d         <= 1'b1;
                we_r            <= d_we;
            end
            if (state == ACCESS && !we_r) begin
                if (owner_d) d_rdata_r <= memory_data_in;
                else         i_rdata_r <= memory_data_in;
            end
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            if (grant_i)      last_i <= 1'b1;
            else if (grant_d) last_i <= 1'b0;
`endif
        end
    end

    assign i_gnt               = grant_i;
    assign d_gnt               = grant_d;
    assign busy                = (state != IDLE);
    assign memory_write_enable = (state == ACCESS) && we_r;
    assign i_rvalid            = (state == RESP) && !owner_d;
    assign d_rvalid            = (state == RESP) && owner_d;
    assign i_rdata             = i_rdata_r;
    // A write completion reports zero without disturbing the last read value.
    assign d_rdata             = (d_rvalid && we_r) ? '0 : d_rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model checked every cycle, directed cases plus random traffic.
// Honours MEM_ARBITER_ROUND_ROBIN_EN the same way as the design.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_gnt, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic [31:0] memory_address, memory_data_out, memory_data_in;
    logic        memory_write_enable, busy;

    int checks = 0;
    int failures = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .memory_address(memory_address), .memory_data_out(memory_data_out),
        .memory_data_in(memory_data_in), .memory_write_enable(memory_write_enable),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Environment memory: 256 words, address bits [9:2].
    logic [31:0] mem [0:255];
    bit          mem_ready = 1'b0;
    assign memory_data_in = mem[memory_address[9:2]];
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
            mem[64] = 32'hDEAD_BEEF;
            mem_ready = 1'b1;
        end else if (memory_write_enable) begin
            mem[memory_address[9:2]] = memory_data_out;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: the transaction in its access cycle and the one in its response cycle.
    logic [31:0] model_mem [0:255];
    bit          model_ready = 1'b0;
    bit          acc_v = 0, acc_d = 0, acc_we = 0;
    logic [31:0] acc_addr = '0, acc_wdata = '0;
    bit          resp_v = 0, resp_d = 0, resp_we = 0;
    bit          last_i = 1;
    logic [31:0] exp_addr = '0, i_hold = '0, d_hold = '0;

    always @(negedge clk) begin
        bit eg_i, eg_d;
        if (!model_ready) begin
            for (int i = 0; i < 256; i++) model_mem[i] = 32'hA500_0000 | i;
            model_mem[64] = 32'hDEAD_BEEF;
            model_ready = 1'b1;
        end
        eg_i = 0;
        eg_d = 0;
        if (!reset && !acc_v) begin
            if (i_req && d_req) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                if (last_i) eg_d = 1; else eg_i = 1;
`else
                eg_d = 1;
`endif
            end else begin
                eg_i = i_req;
                eg_d = d_req;
            end
        end
        chk("i_gnt", {31'b0, i_gnt}, {31'b0, eg_i});
        chk("d_gnt", {31'b0, d_gnt}, {31'b0, eg_d});
        chk("busy", {31'b0, busy}, {31'b0, acc_v || resp_v});
        chk("mem_we", {31'b0, memory_write_enable}, {31'b0, acc_v && acc_we});
        chk("mem_addr", memory_address, exp_addr);
        if (acc_v && acc_we) chk("mem_wdata", memory_data_out, acc_wdata);
        chk("i_rvalid", {31'b0, i_rvalid}, {31'b0, resp_v && !resp_d});
        chk("d_rvalid", {31'b0, d_rvalid}, {31'b0, resp_v && resp_d});
        chk("i_rdata", i_rdata, i_hold);
        chk("d_rdata", d_rdata, (resp_v && resp_d && resp_we) ? 32'h0 : d_hold);

        if (acc_v && acc_we) model_mem[acc_addr[9:2]] = acc_wdata;
        if (reset) begin
            acc_v = 0; resp_v = 0; last_i = 1;
            exp_addr = '0; i_hold = '0; d_hold = '0;
        end else begin
            if (acc_v && !acc_we) begin
                if (acc_d) d_hold = model_mem[acc_addr[9:2]];
                else       i_hold = model_mem[acc_addr[9:2]];
            end
            resp_v = acc_v; resp_d = acc_d; resp_we = acc_we;
            acc_v = eg_i || eg_d;
            if (eg_i) begin
                acc_d = 0; acc_we = 0; acc_addr = i_addr; exp_addr = i_addr; last_i = 1;
            end else if (eg_d) begin
                acc_d = 1; acc_we = d_we; acc_addr = d_addr; acc_wdata = d_wdata;
                exp_addr = d_addr; last_i = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    initial begin
        bit          ig, dg;
        int          gcount;
        logic [7:0]  seq;
        logic [7:0]  seq_exp;

        idle(2);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_addr", memory_address, 32'h0);
        chk("reset_i_rdata", i_rdata, 32'h0);

        // Single fetch
        cyc(); i_req = 1; i_addr = 32'h100;
        @(negedge clk); chk("fetch_gnt", {31'b0, i_gnt}, 32'h1);
        cyc(); i_req = 0;
        @(negedge clk); chk("fetch_addr", memory_address, 32'h100);
        cyc();
        @(negedge clk);
        chk("fetch_rvalid", {31'b0, i_rvalid}, 32'h1);
        chk("fetch_rdata", i_rdata, 32'hDEAD_BEEF);

        // Single write
        idle(2); d_req = 1; d_we = 1; d_addr = 32'h800; d_wdata = 32'h1234_5678;
        @(negedge clk); chk("write_gnt", {31'b0, d_gnt}, 32'h1);
        cyc(); d_req = 0; d_we = 0;
        @(negedge clk);
        chk("write_we", {31'b0, memory_write_enable}, 32'h1);
        chk("write_addr", memory_address, 32'h800);
        chk("write_data", memory_data_out, 32'h1234_5678);
        cyc();
        @(negedge clk);
        chk("write_we_low", {31'b0, memory_write_enable}, 32'h0);
        chk("write_rvalid", {31'b0, d_rvalid}, 32'h1);
        chk("write_rdata", d_rdata, 32'h0);

        // Back-to-back data reads
        idle(2); d_req = 1; d_addr = 32'h800;
        @(negedge clk); chk("b2b_gnt0", {31'b0, d_gnt}, 32'h1);
        cyc(); d_addr = 32'h804;
        @(negedge clk); chk("b2b_nogntA", {31'b0, d_gnt}, 32'h0);
        cyc();
        @(negedge clk);
        chk("b2b_gnt1", {31'b0, d_gnt}, 32'h1);
        chk("b2b_rvalid0", {31'b0, d_rvalid}, 32'h1);
        chk("b2b_rdata0", d_rdata, 32'h1234_5678);
        cyc(); d_req = 0;
        cyc();
        @(negedge clk);
        chk("b2b_rvalid1", {31'b0, d_rvalid}, 32'h1);
        chk("b2b_rdata1", d_rdata, 32'hA500_0001);

        // Reset in the access cycle of a write
        idle(2); d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hCAFE_0001;
        @(negedge clk); chk("rst_wr_gnt", {31'b0, d_gnt}, 32'h1);
        cyc(); d_req = 0; d_we = 0; reset = 1;
        cyc(); reset = 0;
        @(negedge clk);
        chk("rst_wr_busy", {31'b0, busy}, 32'h0);
        chk("rst_wr_we", {31'b0, memory_write_enable}, 32'h0);
        chk("rst_wr_rvalid", {31'b0, d_rvalid}, 32'h0);
        chk("rst_wr_addr", memory_address, 32'h0);

        // Fetch request withdrawn while the data port owns the memory
        idle(2); d_req = 1; d_addr = 32'h10;
        @(negedge clk); chk("wd_dgnt", {31'b0, d_gnt}, 32'h1);
        cyc(); d_req = 0; i_req = 1; i_addr = 32'h3F0;
        @(negedge clk); chk("wd_no_ignt", {31'b0, i_gnt}, 32'h0);
        cyc(); i_req = 0;
        @(negedge clk);
        chk("wd_no_ignt2", {31'b0, i_gnt}, 32'h0);
        chk("wd_rvalid", {31'b0, d_rvalid}, 32'h1);
        idle(3);

        // Contention from a fresh reset
        reset = 1; cyc(); reset = 0;
        i_req = 1; i_addr = 32'h20; d_req = 1; d_we = 0; d_addr = 32'h24;
        gcount = 0; seq = '0;
        for (int n = 0; n < 40 && gcount < 8; n++) begin
            @(negedge clk);
            if (d_gnt) begin seq[gcount] = 1'b1; gcount++; end
            else if (i_gnt) gcount++;
            cyc();
        end
        i_req = 0; d_req = 0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        seq_exp = 8'b0101_0101;
`else
        seq_exp = 8'hFF;
`endif
        chk("contention_count", gcount, 32'd8);
        chk("contention_seq", {24'b0, seq}, {24'b0, seq_exp});
        idle(3);

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            @(negedge clk);
            ig = i_gnt; dg = d_gnt;
            cyc();
            reset = ($urandom_range(0, 99) == 0);
            if (!i_req || ig) begin
                i_req  = $urandom_range(0, 1) == 1;
                i_addr = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
            end else if ($urandom_range(0, 19) == 0) begin
                i_req = 0;
            end
            if (!d_req || dg) begin
                d_req   = $urandom_range(0, 1) == 1;
                d_we    = $urandom_range(0, 1) == 1;
                d_addr  = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
                d_wdata = $urandom;
            end else if ($urandom_range(0, 19) == 0) begin
                d_req = 0;
            end
        end
        reset = 0; i_req = 0; d_req = 0;
        idle(4);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
